lsu_mem_ctrl: RTL and testbench
===============================

LSU_MEM_CTRL -- requirements
Module: lsu_mem_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, 32, data bus width; legal values 32 or 64.
REQ-002 SHALL have parameter ADDR_W, 32, address width.
REQ-003 SHALL have parameter GNT_TIMEOUT, 16, cycles waited for grant before bus error; 0 disables the timeout.
REQ-004 SHALL have port clock  in  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port lsu_en_i  in  1  decode marks the instruction as a memory operation.
REQ-007 SHALL have port lsu_we_i  in  1  1 = store, 0 = load.
REQ-008 SHALL have port lsu_size_i  in  2  00 byte, 01 half, 10 word, 11 double.
REQ-009 SHALL have port lsu_sext_i  in  1  sign-extend load result when 1.
REQ-010 SHALL have port alu_valid_i  in  1  mem_addr_i is valid.
REQ-011 SHALL have port mem_addr_i  in  ADDR_W  byte address from ALU.
REQ-012 SHALL have port store_data_i  in  DATA_W  store operand, right-aligned.
REQ-013 SHALL have port lsu_ready_o  out  1  block can accept an operation.
REQ-014 SHALL have port data_req_o  out  1  memory request.
REQ-015 SHALL have port data_gnt_i  in  1  memory grant.
REQ-016 SHALL have port data_addr_o  out  ADDR_W  bus-aligned address (low offset bits zero).
REQ-017 SHALL have port data_we_o  out  1  write enable.
REQ-018 SHALL have port data_be_o  out  DATA_W/8  byte enables.
REQ-019 SHALL have port data_wdata_o  out  DATA_W  lane-replicated write data.
REQ-020 SHALL have port data_rvalid_i  in  1  read data / write response valid.
REQ-021 SHALL have port data_rdata_i  in  DATA_W  read data.
REQ-022 SHALL have port data_err_i  in  1  bus error, qualified by data_rvalid_i.
REQ-023 SHALL have port resp_valid_o  out  1  one-cycle completion pulse.
REQ-024 SHALL have port load_data_o  out  DATA_W  extracted and extended load result.
REQ-025 SHALL have port misaligned_o  out  1  misaligned or illegal access, valid with resp_valid_o.
REQ-026 SHALL have port bus_err_o  out  1  bus error or grant timeout, valid with resp_valid_o.

Function
REQ-027 SHALL accept an operation when lsu_ready_o & lsu_en_i & alu_valid_i, registering address, size, sign-extend flag, write enable and store data; inputs SHALL be ignored when lsu_ready_o=0.
REQ-028 SHALL implement FSM states IDLE, REQ, WAIT, RESP; lsu_ready_o=1 only in IDLE.
REQ-029 SHALL treat an access as misaligned when: half and addr[0]!=0; word and addr[1:0]!=0; double and addr[2:0]!=0; size 11 with DATA_W=32 is illegal and SHALL be flagged the same way.
REQ-030 SHALL, on a misaligned accept, go IDLE->RESP with no bus request, and SHALL drive misaligned_o=1, bus_err_o=0 and load_data_o=0 in RESP.
REQ-031 SHALL, on an aligned accept, go IDLE->REQ and hold data_req_o=1 with data_addr_o/we/be/wdata stable until the cycle in which data_gnt_i=1, then go to WAIT.
REQ-032 SHALL deassert data_req_o in the cycle after the grant.
REQ-033 SHALL count cycles spent in REQ; when the count reaches GNT_TIMEOUT (nonzero), it SHALL drop data_req_o and enter RESP with bus_err_o=1.
REQ-034 SHALL sample data_rvalid_i only in WAIT, never in the grant cycle; on data_rvalid_i it SHALL capture data_rdata_i and data_err_i and enter RESP.
REQ-035 SHALL assert resp_valid_o for exactly one cycle in RESP, then return to IDLE; minimum latency is accept at cycle 0, req/gnt at 1, rvalid at 2, resp_valid_o at 3.
REQ-036 SHALL generate data_be_o as size mask (1, 3, 0xF or 0xFF bytes) shifted left by the address offset.
REQ-037 SHALL replicate the low byte, half or word of the store operand across all lanes of data_wdata_o.
REQ-038 SHALL extract the load lane selected by the offset and zero- or sign-extend it to DATA_W per lsu_sext_i; loads with bus_err_o=1 SHALL return load_data_o=0.
REQ-039 SHALL drive load_data_o=0 for stores.
REQ-040 SHALL keep resp_valid_o, misaligned_o and bus_err_o at 0 outside RESP.

Reset
REQ-041 SHALL, while reset=0 (asynchronously), force state IDLE and clear the timeout counter and all captured registers.
REQ-042 SHALL drive all outputs to 0 during reset, except lsu_ready_o, which SHALL be 1 after reset release.
REQ-043 SHALL, when reset asserts mid-operation, discard the operation; a subsequent data_rvalid_i in IDLE SHALL be ignored.

Verification
REQ-044 Load byte, addr 0x1003, sext=1, rdata 0x80FFFFFF, gnt at 1, rvalid at 2 -> be=0x8, data_addr_o=0x1000, resp_valid_o at 3, load_data_o=0xFFFFFF80.
REQ-045 Store half, addr 0x2002, data 0x0000BEEF -> be=0xC, wdata=0xBEEFBEEF, we=1, resp_valid_o with load_data_o=0.
REQ-046 Load word, addr 0x3001 -> no data_req_o, resp_valid_o one cycle after accept, misaligned_o=1.
REQ-047 GNT_TIMEOUT=4, gnt held 0 -> data_req_o high 4 cycles, then resp_valid_o=1 with bus_err_o=1.
REQ-048 Load half, addr 0x4000, sext=0, rdata 0x1234F00D, data_err_i=1 -> bus_err_o=1, load_data_o=0.
REQ-049 Reset pulsed in WAIT, then rvalid arrives -> lsu_ready_o=1, no resp_valid_o.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - load/store unit memory-bus controller
// Aligns and requests a single data-bus access per operation, then extracts or extends the load result.
module lsu_mem_ctrl #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int GNT_TIMEOUT = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                lsu_en_i,
  input  logic                lsu_we_i,
  input  logic [1:0]          lsu_size_i,
  input  logic                lsu_sext_i,
  input  logic                alu_valid_i,
  input  logic [ADDR_W-1:0]   mem_addr_i,
  input  logic [DATA_W-1:0]   store_data_i,
  output logic                lsu_ready_o,
  output logic                data_req_o,
  input  logic                data_gnt_i,
  output logic [ADDR_W-1:0]   data_addr_o,
  output logic                data_we_o,
  output logic [DATA_W/8-1:0] data_be_o,
  output logic [DATA_W-1:0]   data_wdata_o,
  input  logic                data_rvalid_i,
  input  logic [DATA_W-1:0]   data_rdata_i,
  input  logic                data_err_i,
  output logic                resp_valid_o,
  output logic [DATA_W-1:0]   load_data_o,
  output logic                misaligned_o,
  output logic                bus_err_o
);

  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam int CNT_W = (GNT_TIMEOUT > 1) ? $clog2(GNT_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((GNT_TIMEOUT > 0) ? GNT_TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [OFF_W-1:0]  off_q;
  logic [1:0]        size_q;
  logic              sext_q;
  logic              we_q;

  logic              accept;
  logic [OFF_W-1:0]  acc_off;
  logic              acc_mis;
  logic [BE_W-1:0]   size_mask;
  logic [BE_W-1:0]   acc_be;
  logic [DATA_W-1:0] acc_wdata;
  logic [DATA_W-1:0] lane;
  logic [DATA_W-1:0] load_ext;

  assign accept  = lsu_ready_o & lsu_en_i & alu_valid_i;
  assign acc_off = mem_addr_i[OFF_W-1:0];

  // Alignment check, byte-enable mask and lane replication for the incoming operation.
  always_comb begin
    acc_mis   = 1'b0;
    size_mask = '0;
    acc_wdata = '0;
    case (lsu_size_i)
      2'b00: begin
        size_mask = BE_W'(1);
        acc_wdata = {BE_W{store_data_i[7:0]}};
      end
      2'b01: begin
        size_mask = BE_W'(3);
        acc_mis   = mem_addr_i[0];
        acc_wdata = {(DATA_W/16){store_data_i[15:0]}};
      end
      2'b10: begin
        size_mask = BE_W'(15);
        acc_mis   = |mem_addr_i[1:0];
        acc_wdata = {(DATA_W/32){store_data_i[31:0]}};
      end
      default: begin
        size_mask = '1;
        acc_mis   = (DATA_W == 32) ? 1'b1 : |mem_addr_i[2:0];
        acc_wdata = store_data_i;
      end
    endcase
    acc_be = size_mask << acc_off;
  end

  // Shift the addressed lane down to bit 0, then extend according to the captured size.
  always_comb begin
    lane     = data_rdata_i >> {off_q, 3'b000};
    load_ext = lane;
    case (size_q)
      2'b00:   load_ext = sext_q ? DATA_W'($signed(lane[7:0]))  : DATA_W'(lane[7:0]);
      2'b01:   load_ext = sext_q ? DATA_W'($signed(lane[15:0])) : DATA_W'(lane[15:0]);
      2'b10:   load_ext = sext_q ? DATA_W'($signed(lane[31:0])) : DATA_W'(lane[31:0]);
      default: load_ext = lane;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      off_q        <= '0;
      size_q       <= '0;
      sext_q       <= 1'b0;
      we_q         <= 1'b0;
      lsu_ready_o  <= 1'b1;
      data_req_o   <= 1'b0;
      data_addr_o  <= '0;
      data_we_o    <= 1'b0;
      data_be_o    <= '0;
      data_wdata_o <= '0;
      resp_valid_o <= 1'b0;
      load_data_o  <= '0;
      misaligned_o <= 1'b0;
      bus_err_o    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            off_q       <= acc_off;
            size_q      <= lsu_size_i;
            sext_q      <= lsu_sext_i;
            we_q        <= lsu_we_i;
            lsu_ready_o <= 1'b0;
            cnt_q       <= '0;
            if (acc_mis) begin
              state_q      <= S_RESP;
              resp_valid_o <= 1'b1;
              misaligned_o <= 1'b1;
              bus_err_o    <= 1'b0;
              load_data_o  <= '0;
            end else begin
              state_q      <= S_REQ;
              data_req_o   <= 1'b1;
              data_addr_o  <= {mem_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
              data_we_o    <= lsu_we_i;
              data_be_o    <= acc_be;
              data_wdata_o <= acc_wdata;
            end
          end
        end
        S_REQ: begin
          if (data_gnt_i) begin
            data_req_o <= 1'b0;
            state_q    <= S_WAIT;
          end else if ((GNT_TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
            data_req_o   <= 1'b0;
            state_q      <= S_RESP;
            resp_valid_o <= 1'b1;
            bus_err_o    <= 1'b1;
            load_data_o  <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_WAIT: begin
          if (data_rvalid_i) begin
            state_q      <= S_RESP;
            resp_valid_o <= 1'b1;
            bus_err_o    <= data_err_i;
            load_data_o  <= (we_q || data_err_i) ? '0 : load_ext;
          end
        end
        default: begin
          state_q      <= S_IDLE;
          resp_valid_o <= 1'b0;
          misaligned_o <= 1'b0;
          bus_err_o    <= 1'b0;
          load_data_o  <= '0;
          lsu_ready_o  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb/tb_lsu_mem_ctrl.sv - directed self-checking bench for lsu_mem_ctrl
module tb_lsu_mem_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        lsu_en_i = 1'b0;
  logic        lsu_we_i = 1'b0;
  logic [1:0]  lsu_size_i = 2'b00;
  logic        lsu_sext_i = 1'b0;
  logic        alu_valid_i = 1'b0;
  logic [31:0] mem_addr_i = '0;
  logic [31:0] store_data_i = '0;
  logic        lsu_ready_o;
  logic        data_req_o;
  logic        data_gnt_i = 1'b0;
  logic [31:0] data_addr_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_wdata_o;
  logic        data_rvalid_i = 1'b0;
  logic [31:0] data_rdata_i = '0;
  logic        data_err_i = 1'b0;
  logic        resp_valid_o;
  logic [31:0] load_data_o;
  logic        misaligned_o;
  logic        bus_err_o;

  int n_tests = 0;
  int n_fail  = 0;

  lsu_mem_ctrl #(.DATA_W(32), .ADDR_W(32), .GNT_TIMEOUT(4)) dut (
    .clock(clock), .reset(reset),
    .lsu_en_i(lsu_en_i), .lsu_we_i(lsu_we_i), .lsu_size_i(lsu_size_i),
    .lsu_sext_i(lsu_sext_i), .alu_valid_i(alu_valid_i), .mem_addr_i(mem_addr_i),
    .store_data_i(store_data_i), .lsu_ready_o(lsu_ready_o), .data_req_o(data_req_o),
    .data_gnt_i(data_gnt_i), .data_addr_o(data_addr_o), .data_we_o(data_we_o),
    .data_be_o(data_be_o), .data_wdata_o(data_wdata_o), .data_rvalid_i(data_rvalid_i),
    .data_rdata_i(data_rdata_i), .data_err_i(data_err_i), .resp_valid_o(resp_valid_o),
    .load_data_o(load_data_o), .misaligned_o(misaligned_o), .bus_err_o(bus_err_o)
  );

  always #5 clock = ~clock;

  // Present one operation for a single cycle; on return we are at the negedge of cycle 1.
  task automatic issue(input logic we, input logic [1:0] size, input logic sext,
                       input logic [31:0] addr, input logic [31:0] sdata);
    @(negedge clock);
    n_tests++;
    if (lsu_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL issue_ready got %b exp 1", lsu_ready_o);
    end
    lsu_en_i = 1'b1; alu_valid_i = 1'b1; lsu_we_i = we; lsu_size_i = size;
    lsu_sext_i = sext; mem_addr_i = addr; store_data_i = sdata;
    @(negedge clock);
    lsu_en_i = 1'b0; alu_valid_i = 1'b0; mem_addr_i = 32'hDEAD_BEEF; store_data_i = '0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) @(negedge clock);
    n_tests++;
    if ({data_req_o, resp_valid_o, misaligned_o, bus_err_o, data_we_o} !== 5'b0 ||
        data_addr_o !== '0 || data_be_o !== '0 || data_wdata_o !== '0 || load_data_o !== '0) begin
      n_fail++; $display("FAIL reset_outputs got req=%b resp=%b addr=%h be=%h", data_req_o, resp_valid_o, data_addr_o, data_be_o);
    end
    reset = 1'b1;
    @(negedge clock);
    n_tests++;
    if (lsu_ready_o !== 1'b1 || resp_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_release got ready=%b resp=%b exp 1/0", lsu_ready_o, resp_valid_o);
    end
  endtask

  task automatic test_load_byte_sext;
    issue(1'b0, 2'b00, 1'b1, 32'h0000_1003, 32'h0);
    n_tests++;
    if (data_req_o !== 1'b1 || data_be_o !== 4'h8 || data_addr_o !== 32'h0000_1000 || data_we_o !== 1'b0) begin
      n_fail++; $display("FAIL lb_req got req=%b be=%h addr=%h we=%b exp 1/8/00001000/0", data_req_o, data_be_o, data_addr_o, data_we_o);
    end
    n_tests++;
    if (lsu_ready_o !== 1'b0) begin
      n_fail++; $display("FAIL lb_busy got ready=%b exp 0", lsu_ready_o);
    end
    data_gnt_i = 1'b1;
    @(negedge clock);
    data_gnt_i = 1'b0;
    n_tests++;
    if (data_req_o !== 1'b0 || resp_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL lb_after_gnt got req=%b resp=%b exp 0/0", data_req_o, resp_valid_o);
    end
    data_rvalid_i = 1'b1; data_rdata_i = 32'h80FF_FFFF;
    @(negedge clock);
    data_rvalid_i = 1'b0;
    n_tests++;
    if (resp_valid_o !== 1'b1 || load_data_o !== 32'hFFFF_FF80 || misaligned_o !== 1'b0 || bus_err_o !== 1'b0) begin
      n_fail++; $display("FAIL lb_resp got v=%b data=%h mis=%b err=%b exp 1/ffffff80/0/0", resp_valid_o, load_data_o, misaligned_o, bus_err_o);
    end
    @(negedge clock);
    n_tests++;
    if (resp_valid_o !== 1'b0 || lsu_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL lb_pulse got v=%b ready=%b exp 0/1", resp_valid_o, lsu_ready_o);
    end
  endtask

  task automatic test_store_half;
    issue(1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h0000_BEEF);
    n_tests++;
    if (data_be_o !== 4'hC || data_wdata_o !== 32'hBEEF_BEEF || data_we_o !== 1'b1 || data_addr_o !== 32'h0000_2000) begin
      n_fail++; $display("FAIL sh_req got be=%h wdata=%h we=%b addr=%h exp c/beefbeef/1/00002000", data_be_o, data_wdata_o, data_we_o, data_addr_o);
    end
    data_gnt_i = 1'b1;
    @(negedge clock);
    data_gnt_i = 1'b0; data_rvalid_i = 1'b1; data_rdata_i = 32'h5555_AAAA;
    @(negedge clock);
    data_rvalid_i = 1'b0;
    n_tests++;
    if (resp_valid_o !== 1'b1 || load_data_o !== 32'h0 || bus_err_o !== 1'b0) begin
      n_fail++; $display("FAIL sh_resp got v=%b data=%h err=%b exp 1/0/0", resp_valid_o, load_data_o, bus_err_o);
    end
    @(negedge clock);
  endtask

  task automatic test_store_byte_repl;
    issue(1'b1, 2'b00, 1'b0, 32'h0000_2001, 32'h1234_56A5);
    n_tests++;
    if (data_be_o !== 4'h2 || data_wdata_o !== 32'hA5A5_A5A5) begin
      n_fail++; $display("FAIL sb_req got be=%h wdata=%h exp 2/a5a5a5a5", data_be_o, data_wdata_o);
    end
    data_gnt_i = 1'b1;
    @(negedge clock);
    data_gnt_i = 1'b0; data_rvalid_i = 1'b1;
    @(negedge clock);
    data_rvalid_i = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_misaligned(input logic [1:0] size, input logic [31:0] addr);
    issue(1'b0, size, 1'b0, addr, 32'h0);
    n_tests++;
    if (resp_valid_o !== 1'b1 || misaligned_o !== 1'b1 || bus_err_o !== 1'b0 || data_req_o !== 1'b0 || load_data_o !== 32'h0) begin
      n_fail++; $display("FAIL mis_%0d_%h got v=%b mis=%b err=%b req=%b data=%h exp 1/1/0/0/0", size, addr, resp_valid_o, misaligned_o, bus_err_o, data_req_o, load_data_o);
    end
    @(negedge clock);
    n_tests++;
    if (resp_valid_o !== 1'b0 || misaligned_o !== 1'b0 || lsu_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL mis_clear got v=%b mis=%b ready=%b exp 0/0/1", resp_valid_o, misaligned_o, lsu_ready_o);
    end
  endtask

  task automatic test_timeout;
    issue(1'b0, 2'b10, 1'b0, 32'h0000_5000, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      n_tests++;
      if (data_req_o !== 1'b1 || resp_valid_o !== 1'b0) begin
        n_fail++; $display("FAIL to_req_cyc%0d got req=%b resp=%b exp 1/0", i, data_req_o, resp_valid_o);
      end
      @(negedge clock);
    end
    n_tests++;
    if (data_req_o !== 1'b0 || resp_valid_o !== 1'b1 || bus_err_o !== 1'b1 || load_data_o !== 32'h0) begin
      n_fail++; $display("FAIL to_resp got req=%b v=%b err=%b data=%h exp 0/1/1/0", data_req_o, resp_valid_o, bus_err_o, load_data_o);
    end
    @(negedge clock);
  endtask

  task automatic test_half_loads;
    // Offset-2 zero-extended half, then offset-0 sign-extended half.
    issue(1'b0, 2'b01, 1'b0, 32'h0000_4002, 32'h0);
    data_gnt_i = 1'b1;
    @(negedge clock);
    data_gnt_i = 1'b0; data_rvalid_i = 1'b1; data_rdata_i = 32'h8765_F00D;
    @(negedge clock);
    data_rvalid_i = 1'b0;
    n_tests++;
    if (resp_valid_o !== 1'b1 || load_data_o !== 32'h0000_8765) begin
      n_fail++; $display("FAIL lhu_resp got v=%b data=%h exp 1/00008765", resp_valid_o, load_data_o);
    end
    @(negedge clock);
    issue(1'b0, 2'b01, 1'b1, 32'h0000_4000, 32'h0);
    data_gnt_i = 1'b1;
    @(negedge clock);
    data_gnt_i = 1'b0; data_rvalid_i = 1'b1; data_rdata_i = 32'h1234_F00D;
    @(negedge clock);
    data_rvalid_i = 1'b0;
    n_tests++;
    if (resp_valid_o !== 1'b1 || load_data_o !== 32'hFFFF_F00D) begin
      n_fail++; $display("FAIL lh_resp got v=%b data=%h exp 1/fffff00d", resp_valid_o, load_data_o);
    end
    @(negedge clock);
  endtask

  task automatic test_bus_err;
    issue(1'b0, 2'b01, 1'b0, 32'h0000_4000, 32'h0);
    data_gnt_i = 1'b1;
    @(negedge clock);
    data_gnt_i = 1'b0; data_rvalid_i = 1'b1; data_rdata_i = 32'h1234_F00D; data_err_i = 1'b1;
    @(negedge clock);
    data_rvalid_i = 1'b0; data_err_i = 1'b0;
    n_tests++;
    if (resp_valid_o !== 1'b1 || bus_err_o !== 1'b1 || load_data_o !== 32'h0 || misaligned_o !== 1'b0) begin
      n_fail++; $display("FAIL berr_resp got v=%b err=%b data=%h mis=%b exp 1/1/0/0", resp_valid_o, bus_err_o, load_data_o, misaligned_o);
    end
    @(negedge clock);
  endtask

  task automatic test_rvalid_in_gnt_cycle;
    // rvalid coinciding with the grant must not complete the access.
    issue(1'b0, 2'b10, 1'b0, 32'h0000_6004, 32'h0);
    data_gnt_i = 1'b1; data_rvalid_i = 1'b1; data_rdata_i = 32'h1111_1111;
    @(negedge clock);
    data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
    @(negedge clock);
    n_tests++;
    if (resp_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL gnt_rvalid_ignored got v=%b exp 0", resp_valid_o);
    end
    data_rvalid_i = 1'b1; data_rdata_i = 32'hCAFE_0123;
    @(negedge clock);
    data_rvalid_i = 1'b0;
    n_tests++;
    if (resp_valid_o !== 1'b1 || load_data_o !== 32'hCAFE_0123) begin
      n_fail++; $display("FAIL gnt_rvalid_late got v=%b data=%h exp 1/cafe0123", resp_valid_o, load_data_o);
    end
    @(negedge clock);
  endtask

  task automatic test_reset_in_wait;
    issue(1'b0, 2'b10, 1'b0, 32'h0000_7000, 32'h0);
    data_gnt_i = 1'b1;
    @(negedge clock);
    data_gnt_i = 1'b0;
    reset = 1'b0;
    #1;
    n_tests++;
    if (data_req_o !== 1'b0 || resp_valid_o !== 1'b0 || data_addr_o !== 32'h0) begin
      n_fail++; $display("FAIL rst_wait_async got req=%b v=%b addr=%h exp 0/0/0", data_req_o, resp_valid_o, data_addr_o);
    end
    @(negedge clock);
    reset = 1'b1;
    data_rvalid_i = 1'b1; data_rdata_i = 32'h7777_7777;
    @(negedge clock);
    data_rvalid_i = 1'b0;
    n_tests++;
    if (lsu_ready_o !== 1'b1 || resp_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL rst_wait_rvalid got ready=%b v=%b exp 1/0", lsu_ready_o, resp_valid_o);
    end
    @(negedge clock);
    n_tests++;
    if (lsu_ready_o !== 1'b1 || resp_valid_o !== 1'b0 || load_data_o !== 32'h0) begin
      n_fail++; $display("FAIL rst_wait_idle got ready=%b v=%b data=%h exp 1/0/0", lsu_ready_o, resp_valid_o, load_data_o);
    end
  endtask

  initial begin
    test_reset();
    test_load_byte_sext();
    test_store_half();
    test_store_byte_repl();
    test_misaligned(2'b10, 32'h0000_3001);
    test_misaligned(2'b01, 32'h0000_3003);
    test_misaligned(2'b11, 32'h0000_6000);
    test_timeout();
    test_half_loads();
    test_bus_err();
    test_rvalid_in_gnt_cycle();
    test_reset_in_wait();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
